// File: rtl/cic_iq_decimator_pkg.sv
`default_nettype none
// ============================================================================
// cic_iq_decimator_pkg - shared FSM encoding, default sizes and width helpers
// Rev 1.0
// ============================================================================
package cic_iq_decimator_pkg;

   typedef enum logic [1:0] {
      CIC_IDLE   = 2'b00,
      CIC_COMB_I = 2'b01,
      CIC_COMB_Q = 2'b10
   } cic_state_e;

   localparam int CIC_ISZ = 12;
   localparam int CIC_OSZ = 16;
   localparam int CIC_N   = 3;
   localparam int CIC_R   = 8;
   localparam int CIC_RSZ = 3;

   // Full CIC bit growth: each stage adds log2(R) bits.
   function automatic int cic_wsz(input int isz, input int n, input int rsz);
      return isz + n * rsz;
   endfunction

   // Bit position of the half-LSB added before truncating to the output width.
   function automatic int cic_rnd_shift(input int wsz, input int osz);
      return wsz - osz - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cic_integrator_chain.sv
`default_nettype none
// ============================================================================
// cic_integrator_chain - N cascaded wrapping integrators for one CIC channel
// Rev 1.0
// ============================================================================
module cic_integrator_chain
   import cic_iq_decimator_pkg::*;
#(
   parameter int ISZ = CIC_ISZ,
   parameter int N   = CIC_N,
   parameter int WSZ = cic_wsz(CIC_ISZ, CIC_N, CIC_RSZ)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   input  logic [ISZ-1:0] din,
   output logic [WSZ-1:0] acc_next
);

   logic [WSZ-1:0] acc_q [N];
   logic [WSZ-1:0] acc_d [N];

   // Stages ripple within the cycle, so acc_next already holds this sample.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         acc_d[k] = acc_q[k];
      end
      if (en) begin
         acc_d[0] = acc_q[0] + {{(WSZ-ISZ){din[ISZ-1]}}, din};
         for (int k = 1; k < N; k++) begin
            acc_d[k] = acc_q[k] + acc_d[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N; k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign acc_next = acc_d[N-1];

endmodule
`default_nettype wire

// File: rtl/cic_iq_decimator.sv
`default_nettype none
// ============================================================================
// cic_iq_decimator - dual-channel CIC decimator with interleaved I/Q output
// Rev 1.0
// ============================================================================
module cic_iq_decimator
   import cic_iq_decimator_pkg::*;
#(
   parameter int ISZ = CIC_ISZ,
   parameter int OSZ = CIC_OSZ,
   parameter int N   = CIC_N,
   parameter int R   = CIC_R,
   parameter int RSZ = CIC_RSZ
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic signed [ISZ-1:0] in_i,
   input  logic signed [ISZ-1:0] in_q,
   output logic                  out_valid,
   output logic signed [OSZ-1:0] out,
   output logic                  out_iq
);

   localparam int           WSZ = cic_wsz(ISZ, N, RSZ);
   localparam logic [WSZ:0] RND = (WSZ+1)'(1) << cic_rnd_shift(WSZ, OSZ);

   cic_state_e     state_q, state_d;
   logic [RSZ-1:0] cnt_q, cnt_d;
   logic           decim;
   logic [WSZ-1:0] acc_i, acc_q;
   logic [WSZ-1:0] samp_i_q, samp_i_d, samp_q_q, samp_q_d;
   logic [WSZ-1:0] dly_i_q [N];
   logic [WSZ-1:0] dly_i_d [N];
   logic [WSZ-1:0] dly_q_q [N];
   logic [WSZ-1:0] dly_q_d [N];
   logic [WSZ-1:0] stage [N+1];
   logic [WSZ:0]   rnd_sum;
   logic [OSZ:0]   rnd_top;
   logic [OSZ-1:0] word;
   logic           rnd_unused;
   logic [OSZ-1:0] out_q, out_d;
   logic           out_valid_q, out_valid_d;
   logic           out_iq_q, out_iq_d;

   cic_integrator_chain #(.ISZ(ISZ), .N(N), .WSZ(WSZ)) u_int_i (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (in_valid),
      .din      (in_i),
      .acc_next (acc_i)
   );

   cic_integrator_chain #(.ISZ(ISZ), .N(N), .WSZ(WSZ)) u_int_q (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (in_valid),
      .din      (in_q),
      .acc_next (acc_q)
   );

   always_comb begin
      decim = in_valid && (cnt_q == RSZ'(R - 1));
      cnt_d = cnt_q;
      if (in_valid) begin
         cnt_d = decim ? '0 : cnt_q + RSZ'(1);
      end
      samp_i_d = decim ? acc_i : samp_i_q;
      samp_q_d = decim ? acc_q : samp_q_q;
   end

   // Shared comb chain; the active channel's delay line feeds the subtractors.
   always_comb begin
      stage[0] = (state_q == CIC_COMB_Q) ? samp_q_q : samp_i_q;
      for (int k = 0; k < N; k++) begin
         stage[k+1] = stage[k] - ((state_q == CIC_COMB_Q) ? dly_q_q[k] : dly_i_q[k]);
         dly_i_d[k] = (state_q == CIC_COMB_I) ? stage[k] : dly_i_q[k];
         dly_q_d[k] = (state_q == CIC_COMB_Q) ? stage[k] : dly_q_q[k];
      end
      rnd_sum = {stage[N][WSZ-1], stage[N]} + RND;
      rnd_top = rnd_sum[WSZ -: OSZ+1];
      if (!rnd_top[OSZ] && rnd_top[OSZ-1]) begin
         word = {1'b0, {(OSZ-1){1'b1}}};
      end else begin
         word = rnd_top[OSZ-1:0];
      end
   end

   assign rnd_unused = ^rnd_sum[WSZ-OSZ-1:0];

   // R >= 2 guarantees no decimation event lands while in COMB_I.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      out_iq_d    = out_iq_q;
      case (state_q)
         CIC_IDLE: begin
            if (decim) begin
               state_d = CIC_COMB_I;
            end
         end
         CIC_COMB_I: begin
            state_d     = CIC_COMB_Q;
            out_d       = word;
            out_valid_d = 1'b1;
            out_iq_d    = 1'b0;
         end
         CIC_COMB_Q: begin
            state_d     = decim ? CIC_COMB_I : CIC_IDLE;
            out_d       = word;
            out_valid_d = 1'b1;
            out_iq_d    = 1'b1;
         end
         default: begin
            state_d = CIC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CIC_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         samp_i_q    <= '0;
         samp_q_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_iq_q    <= 1'b0;
         for (int k = 0; k < N; k++) begin
            dly_i_q[k] <= '0;
            dly_q_q[k] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         samp_i_q    <= samp_i_d;
         samp_q_q    <= samp_q_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_iq_q    <= out_iq_d;
         for (int k = 0; k < N; k++) begin
            dly_i_q[k] <= dly_i_d[k];
            dly_q_q[k] <= dly_q_d[k];
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_iq    = out_iq_q;

endmodule
`default_nettype wire
